// File: rtl/process_monitor_seq_pkg.sv
// Shared definitions for the ring-oscillator process monitor:
// FSM state encoding, default parameter values and a timer width helper.
package process_monitor_seq_pkg;

  localparam int DEF_NB_MONITOR    = 4;
  localparam int DEF_COUNT_W       = 16;
  localparam int DEF_TARGET_W      = 16;
  localparam int DEF_SETTLE_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  // One down-counter times both the settle and the measure phases, so it
  // must be wide enough for whichever of the two is longer.
  function automatic int timer_width(input int target_w, input int settle_cycles);
    int settle_w;
    settle_w = $clog2(settle_cycles + 1);
    return (target_w > settle_w) ? target_w : settle_w;
  endfunction

endpackage

// File: rtl/process_monitor_seq_cnt.sv
// One saturating event counter: synchronous clear has priority over the
// increment, and the count sticks at all-ones instead of wrapping.
// The combinational next value is exported so the parent can capture a
// result that includes an event arriving on the final measurement cycle.
module process_monitor_seq_cnt
  import process_monitor_seq_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [COUNT_W-1:0] o_count_next
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] count_next;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_next = count_reg;
    if (i_clr) begin
      count_next = '0;
    end else if (i_inc && (count_reg != COUNT_MAX)) begin
      count_next = count_reg + COUNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign o_count_next = count_next;

endmodule

// File: rtl/process_monitor_seq.sv
// Ring-oscillator process monitor sequencer.
// IDLE -> SETTLE (ROs enabled, pulses ignored) -> MEASURE (count pulses for
// the latched window) -> REPORT (one-cycle o_valid with the new counts).
// Optional sticky threshold alarms are compiled in when the macro
// PROCESS_MONITOR_SEQ_ALARM_EN is defined; otherwise the alarm outputs are 0.
module process_monitor_seq
  import process_monitor_seq_pkg::*;
#(
  parameter int NB_MONITOR    = DEF_NB_MONITOR,
  parameter int COUNT_W       = DEF_COUNT_W,
  parameter int TARGET_W      = DEF_TARGET_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_enable,
  input  logic                               i_start,
  input  logic                               i_continuous,
  input  logic [TARGET_W-1:0]                i_target,
  input  logic [NB_MONITOR-1:0]              i_use_ro,
  input  logic [NB_MONITOR-1:0]              i_ro_pulse,
  input  logic [COUNT_W-1:0]                 i_thr_lo,
  input  logic [COUNT_W-1:0]                 i_thr_hi,
  input  logic                               i_alarm_clr,
  output logic [NB_MONITOR-1:0]              o_ro_en,
  output logic                               o_busy,
  output logic                               o_valid,
  output logic [NB_MONITOR-1:0][COUNT_W-1:0] o_count,
  output logic [NB_MONITOR-1:0]              o_alarm_lo,
  output logic [NB_MONITOR-1:0]              o_alarm_hi
);

  localparam int TIMER_W = timer_width(TARGET_W, SETTLE_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  state_t                             state_reg, state_next;
  logic [TIMER_W-1:0]                 timer_reg, timer_next;
  logic [TARGET_W-1:0]                target_reg, target_next;
  logic [NB_MONITOR-1:0]              mask_reg, mask_next;
  logic [NB_MONITOR-1:0][COUNT_W-1:0] count_reg;
  logic [NB_MONITOR-1:0][COUNT_W-1:0] cnt_next;
  logic [NB_MONITOR-1:0]              cnt_inc;
  logic                               cnt_clr;
  logic                               load_result;

  // Next-state, phase timer and latched configuration.
  // load_result marks the edge entering REPORT, where the counts are captured.
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    target_next = target_reg;
    mask_next   = mask_reg;
    load_result = 1'b0;
    if (!i_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_start || i_continuous) begin
            state_next  = ST_SETTLE;
            target_next = i_target;
            mask_next   = i_use_ro;
            timer_next  = SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (timer_reg == '0) begin
            if (target_reg == '0) begin
              state_next  = ST_REPORT;
              load_result = 1'b1;
            end else begin
              state_next = ST_MEASURE;
              timer_next = TIMER_W'(target_reg) - TIMER_W'(1);
            end
          end else begin
            timer_next = timer_reg - TIMER_W'(1);
          end
        end
        ST_MEASURE: begin
          if (timer_reg == '0) begin
            state_next  = ST_REPORT;
            load_result = 1'b1;
          end else begin
            timer_next = timer_reg - TIMER_W'(1);
          end
        end
        ST_REPORT: begin
          if (i_continuous) begin
            target_next = i_target;
            mask_next   = i_use_ro;
            // A new channel set needs its oscillators to settle again.
            if (i_use_ro != mask_reg) begin
              state_next = ST_SETTLE;
              timer_next = SETTLE_LOAD;
            end else if (i_target == '0) begin
              state_next  = ST_REPORT;
              load_result = 1'b1;
            end else begin
              state_next = ST_MEASURE;
              timer_next = TIMER_W'(i_target) - TIMER_W'(1);
            end
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // FSM, timer and configuration registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      target_reg <= '0;
      mask_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      target_reg <= target_next;
      mask_reg   <= mask_next;
    end
  end

  // Counters run only in MEASURE; every other state (or a disable) holds them at 0,
  // so each window starts from zero without extra bookkeeping.
  assign cnt_clr = (state_reg != ST_MEASURE) || !i_enable;

  genvar gi;
  generate
    for (gi = 0; gi < NB_MONITOR; gi++) begin : g_cnt
      assign cnt_inc[gi] = i_ro_pulse[gi] & mask_reg[gi];
      process_monitor_seq_cnt #(
        .COUNT_W (COUNT_W)
      ) u_cnt (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (cnt_clr),
        .i_inc        (cnt_inc[gi]),
        .o_count_next (cnt_next[gi])
      );
    end
  endgenerate

  // Result register: captured on entry to REPORT, held otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else if (load_result) begin
      for (int i = 0; i < NB_MONITOR; i++) begin
        count_reg[i] <= mask_reg[i] ? cnt_next[i] : '0;
      end
    end
  end

`ifdef PROCESS_MONITOR_SEQ_ALARM_EN
  logic [NB_MONITOR-1:0] alarm_lo_reg, alarm_hi_reg;
  logic [NB_MONITOR-1:0] set_lo, set_hi;

  generate
    for (gi = 0; gi < NB_MONITOR; gi++) begin : g_alarm
      assign set_lo[gi] = load_result & mask_reg[gi] & (cnt_next[gi] < i_thr_lo);
      assign set_hi[gi] = load_result & mask_reg[gi] & (cnt_next[gi] > i_thr_hi);
    end
  endgenerate

  // Sticky alarms; a new set beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alarm_lo_reg <= '0;
      alarm_hi_reg <= '0;
    end else begin
      alarm_lo_reg <= set_lo | (alarm_lo_reg & {NB_MONITOR{~i_alarm_clr}});
      alarm_hi_reg <= set_hi | (alarm_hi_reg & {NB_MONITOR{~i_alarm_clr}});
    end
  end

  assign o_alarm_lo = alarm_lo_reg;
  assign o_alarm_hi = alarm_hi_reg;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{i_thr_lo, i_thr_hi, i_alarm_clr};
  assign o_alarm_lo = '0;
  assign o_alarm_hi = '0;
`endif

  assign o_busy  = (state_reg != ST_IDLE);
  assign o_valid = (state_reg == ST_REPORT) && i_enable;
  assign o_ro_en = o_busy ? mask_reg : '0;
  assign o_count = count_reg;

endmodule

// File: tb/tb_process_monitor_seq.sv
// Bench for process_monitor_seq: directed scenarios with random RO pulses,
// expected counts computed per window from the pulses actually driven.
`timescale 1ns/1ps
module tb_process_monitor_seq;

  localparam int S = 8;
`ifdef PROCESS_MONITOR_SEQ_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] target = '0;
  logic [3:0]  use_ro = '0;
  logic [3:0]  ro_pulse = '0;
  logic [15:0] thr_lo = '0;
  logic [15:0] thr_hi = 16'hFFFF;
  logic        alarm_clr = 1'b0;

  logic [3:0]       ro_en, alarm_lo, alarm_hi;
  logic             busy, valid;
  logic [3:0][15:0] count;
  logic [3:0]       s_ro_en, s_alarm_lo, s_alarm_hi;
  logic             s_busy, s_valid;
  logic [3:0][3:0]  s_count;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] last_count = '0;
  logic [3:0]  exp_lo = '0;
  logic [3:0]  exp_hi = '0;

  always #5 clk = ~clk;

  process_monitor_seq u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start),
    .i_continuous(continuous), .i_target(target), .i_use_ro(use_ro),
    .i_ro_pulse(ro_pulse), .i_thr_lo(thr_lo), .i_thr_hi(thr_hi),
    .i_alarm_clr(alarm_clr), .o_ro_en(ro_en), .o_busy(busy), .o_valid(valid),
    .o_count(count), .o_alarm_lo(alarm_lo), .o_alarm_hi(alarm_hi)
  );

  process_monitor_seq #(.COUNT_W(4)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start),
    .i_continuous(continuous), .i_target(target), .i_use_ro(use_ro),
    .i_ro_pulse(ro_pulse), .i_thr_lo(thr_lo[3:0]), .i_thr_hi(thr_hi[3:0]),
    .i_alarm_clr(alarm_clr), .o_ro_en(s_ro_en), .o_busy(s_busy), .o_valid(s_valid),
    .o_count(s_count), .o_alarm_lo(s_alarm_lo), .o_alarm_hi(s_alarm_hi)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ch0 every 2, ch2 every 4, ch1 always, ch3 random
  // mode 1: fully random; mode 2: all channels every cycle
  // mode 3: ch0 10/50, ch1 30/50, ch2 every cycle, ch3 random
  function automatic logic [3:0] gen_pulse(input int mode, input int k);
    logic [3:0] p;
    case (mode)
      0: p = {1'($urandom), 1'(k % 4 == 0), 1'b1, 1'(k % 2 == 0)};
      2: p = 4'hF;
      3: p = {1'($urandom), 1'b1, 1'(k % 5 < 3), 1'(k % 5 == 0)};
      default: p = 4'($urandom);
    endcase
    return p;
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_ro_en"}, 64'(ro_en), 64'd0);
  endtask

  // Runs nwin back-to-back windows (nwin>1 uses i_continuous, else i_start)
  // with a fixed mask and target; checks every cycle against the schedule
  // settle(S) then nwin x (measure(tgt) + report(1)).
  task automatic run_meas(input logic [3:0] mask, input int tgt, input int mode,
                          input int nwin, input bit clr_last);
    int acc[4];
    int total, win, j;
    bit is_rep, is_meas;
    logic [63:0] e;
    logic [15:0] es;
    logic [3:0] p;
    @(negedge clk);
    use_ro = mask;
    target = 16'(tgt);
    if (nwin > 1) continuous = 1'b1; else start = 1'b1;
    ro_pulse = 4'($urandom);
    for (int i = 0; i < 4; i++) acc[i] = 0;
    total = S + nwin * (tgt + 1);
    win = 0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      start = 1'b0;
      alarm_clr = 1'b0;
      is_rep = 1'b0;
      is_meas = 1'b0;
      j = 0;
      if (k > S) begin
        j = (k - S - 1) % (tgt + 1);
        is_rep = (j == tgt);
        is_meas = (j < tgt);
      end
      chk("valid", 64'(valid), 64'(is_rep));
      chk("busy", 64'(busy), 64'd1);
      chk("ro_en", 64'(ro_en), 64'(mask));
      if (is_rep) begin
        for (int i = 0; i < 4; i++) begin
          e[i*16 +: 16] = (acc[i] > 65535) ? 16'hFFFF : 16'(acc[i]);
          es[i*4 +: 4]  = (acc[i] > 15) ? 4'hF : 4'(acc[i]);
          if (ALARM && mask[i]) begin
            if (acc[i] < int'(thr_lo)) exp_lo[i] = 1'b1;
            if (acc[i] > int'(thr_hi)) exp_hi[i] = 1'b1;
          end
          acc[i] = 0;
        end
        last_count = e;
        chk("count", count, e);
        chk("sat_count", 64'(s_count), 64'(es));
        chk("alarm_lo", 64'(alarm_lo), 64'(exp_lo));
        chk("alarm_hi", 64'(alarm_hi), 64'(exp_hi));
        $display("window %0d: mask=%b target=%0d count=%h valid@cycle %0d", win, mask, tgt, count, k);
        win++;
        if (win == nwin) continuous = 1'b0;
      end
      p = gen_pulse(mode, k);
      ro_pulse = p;
      if (is_meas) begin
        for (int i = 0; i < 4; i++) acc[i] += int'(p[i] & mask[i]);
        // Clear lands on the same edge that sets the alarms: sets must win.
        if (clr_last && j == tgt - 1) begin
          alarm_clr = 1'b1;
          exp_lo = '0;
          exp_hi = '0;
        end
      end
    end
    @(negedge clk);
    idle_checks("post");
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 64'd0);
    idle_checks("rst");
    chk("rst_alarm", 64'({alarm_lo, alarm_hi}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    idle_checks("idle");

    // Single shot, mask 0101, target 100
    run_meas(4'b0101, 100, 0, 1, 1'b0);
    chk("single_const", count, 64'h0000_0019_0000_0032);

    // Saturation: 4-bit instance holds at 15 with 40 pulses
    run_meas(4'b0001, 40, 2, 1, 1'b0);
    chk("sat_const", 64'(s_count), 64'h000F);

    // Continuous, constant mask, target 10, three windows
    run_meas(4'b1011, 10, 1, 3, 1'b0);

    // Abort at 5th measure cycle
    @(negedge clk);
    use_ro = 4'hF; target = 16'd50; start = 1'b1;
    for (int k = 1; k <= S + 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      ro_pulse = 4'($urandom);
      chk("abort_valid", 64'(valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd1);
    end
    enable = 1'b0;
    @(negedge clk);
    idle_checks("abort");
    chk("abort_count", count, last_count);
    $display("abort: busy=%b ro_en=%b count=%h", busy, ro_en, count);
    repeat (3) begin
      @(negedge clk);
      idle_checks("abort_hold");
    end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    idle_checks("abort_resume");

    // Alarms: counts {50,30,10} on ch2..ch0 against 20/40
    thr_lo = 16'd20; thr_hi = 16'd40;
    run_meas(4'b0111, 50, 3, 1, 1'b0);
    run_meas(4'b0111, 50, 3, 1, 1'b1);
    @(negedge clk);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    exp_lo = '0; exp_hi = '0;
    chk("alarm_clr_lo", 64'(alarm_lo), 64'(exp_lo));
    chk("alarm_clr_hi", 64'(alarm_hi), 64'(exp_hi));
    $display("alarm clear: lo=%b hi=%b", alarm_lo, alarm_hi);
    thr_lo = 16'd0; thr_hi = 16'hFFFF;

    // Async reset during SETTLE
    @(negedge clk);
    use_ro = 4'b0011; target = 16'd0; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    idle_checks("rst_settle");
    chk("rst_settle_count", count, 64'd0);
    chk("rst_settle_alarm", 64'({alarm_lo, alarm_hi}), 64'd0);
    last_count = '0; exp_lo = '0; exp_hi = '0;
    $display("reset in settle: busy=%b count=%h", busy, count);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_checks("post_rst");
    end

    // Target 0: report right after settle, zero counts
    run_meas(4'b0011, 0, 2, 1, 1'b0);

    // Random scenarios
    for (int r = 0; r < 4; r++) begin
      run_meas(4'($urandom), $urandom_range(1, 30), 1, $urandom_range(1, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
